// File: rtl/sha256_msg_packer_pkg.sv
// Shared SHA-256 definitions: block-layout limits, packer state encoding,
// and the initial hash / round constants used by the core.
package sha256_msg_packer_pkg;

    localparam int         MAX_BYTES = 55;
    localparam int         NUM_WORDS = 14;
    localparam logic [7:0] PAD_BYTE  = 8'h80;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PRESENT = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_msg_packer.sv
// Packs an AXI4-Stream byte message big-endian into one SHA-256 block
// (words 0..13 plus 0x80 marker) and hands it to the core via string_dv/string_ready.
module sha256_msg_packer
    import sha256_msg_packer_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] string_w0,
    output logic [31:0] string_w1,
    output logic [31:0] string_w2,
    output logic [31:0] string_w3,
    output logic [31:0] string_w4,
    output logic [31:0] string_w5,
    output logic [31:0] string_w6,
    output logic [31:0] string_w7,
    output logic [31:0] string_w8,
    output logic [31:0] string_w9,
    output logic [31:0] string_w10,
    output logic [31:0] string_w11,
    output logic [31:0] string_w12,
    output logic [31:0] string_w13,
    output logic [7:0]  string_size,
    output logic        string_dv,
    input  logic        string_ready,
    output logic        overflow_err
);

    localparam logic [5:0] CNT_FULL = 6'(MAX_BYTES);

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [7:0]  size_q;
    logic        dv_q;
    logic        ovf_q;
    logic        tready_q;
    logic [31:0] buf_q [NUM_WORDS];
    logic [31:0] buf_d [NUM_WORDS];

    logic        accept;
    logic        wr_byte;
    logic        wr_pad;
    logic        clr;
    logic [5:0]  cnt_nxt;
    logic [5:0]  idx;
    logic [7:0]  lane;

    always_comb begin
        accept  = s_axis_tvalid && tready_q;
        wr_byte = accept && (state_q == ST_COLLECT) && (cnt_q < CNT_FULL);
        wr_pad  = wr_byte && s_axis_tlast;
        cnt_nxt = cnt_q + 6'd1;
        // Buffer is wiped on handoff and on the tlast that ends a dropped message.
        clr     = ((state_q == ST_PRESENT) && string_ready)
               || (accept && s_axis_tlast && (state_q == ST_DROP))
               || (accept && s_axis_tlast && (state_q == ST_COLLECT) && (cnt_q == CNT_FULL));
        idx     = '0;
        lane    = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int l = 0; l < 4; l++) begin
                idx  = 6'(4 * w + 3 - l);
                lane = clr ? 8'h00 : buf_q[w][8*l +: 8];
                if (wr_byte && (idx == cnt_q))  lane = s_axis_tdata;
                if (wr_pad && (idx == cnt_nxt)) lane = PAD_BYTE;
                buf_d[w][8*l +: 8] = lane;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_COLLECT;
            cnt_q    <= '0;
            size_q   <= '0;
            dv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            tready_q <= 1'b1;
            for (int w = 0; w < NUM_WORDS; w++) buf_q[w] <= '0;
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) buf_q[w] <= buf_d[w];
            ovf_q <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (accept) begin
                        if (cnt_q < CNT_FULL) begin
                            cnt_q <= cnt_nxt;
                            if (s_axis_tlast) begin
                                size_q   <= {2'b00, cnt_q} + 8'd1;
                                dv_q     <= 1'b1;
                                tready_q <= 1'b0;
                                state_q  <= ST_PRESENT;
                            end
                        end else if (s_axis_tlast) begin
                            ovf_q <= 1'b1;
                            cnt_q <= '0;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (accept && s_axis_tlast) begin
                        ovf_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_PRESENT: begin
                    if (string_ready) begin
                        dv_q     <= 1'b0;
                        tready_q <= 1'b1;
                        cnt_q    <= '0;
                        size_q   <= '0;
                        state_q  <= ST_COLLECT;
                    end
                end
                default: begin
                    state_q  <= ST_COLLECT;
                    dv_q     <= 1'b0;
                    tready_q <= 1'b1;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign s_axis_tready = tready_q;
    assign string_dv     = dv_q;
    assign string_size   = size_q;
    assign overflow_err  = ovf_q;
    assign string_w0     = buf_q[0];
    assign string_w1     = buf_q[1];
    assign string_w2     = buf_q[2];
    assign string_w3     = buf_q[3];
    assign string_w4     = buf_q[4];
    assign string_w5     = buf_q[5];
    assign string_w6     = buf_q[6];
    assign string_w7     = buf_q[7];
    assign string_w8     = buf_q[8];
    assign string_w9     = buf_q[9];
    assign string_w10    = buf_q[10];
    assign string_w11    = buf_q[11];
    assign string_w12    = buf_q[12];
    assign string_w13    = buf_q[13];

endmodule

// File: tb/tb_sha256_msg_packer.sv
// Directed bench for sha256_msg_packer: message-level reference model plus
// literal expectations for the canonical messages.
module tb_sha256_msg_packer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] w [14];
    logic [7:0]  string_size;
    logic        string_dv;
    logic        string_ready;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state: bytes of the message in flight, pending block.
    logic [7:0]  msg [$];
    bit          m_pend;
    bit          m_ovf;
    logic [31:0] m_words [14];
    logic [7:0]  m_size;

    sha256_msg_packer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .string_w0     (w[0]),
        .string_w1     (w[1]),
        .string_w2     (w[2]),
        .string_w3     (w[3]),
        .string_w4     (w[4]),
        .string_w5     (w[5]),
        .string_w6     (w[6]),
        .string_w7     (w[7]),
        .string_w8     (w[8]),
        .string_w9     (w[9]),
        .string_w10    (w[10]),
        .string_w11    (w[11]),
        .string_w12    (w[12]),
        .string_w13    (w[13]),
        .string_size   (string_size),
        .string_dv     (string_dv),
        .string_ready  (string_ready),
        .overflow_err  (overflow_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A message of up to 55 bytes becomes: bytes, then 0x80, then zeros, big-endian.
    always @(posedge aclk) begin
        if (!aresetn) begin
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            m_size = 8'd0;
            msg.delete();
            for (int i = 0; i < 14; i++) m_words[i] = 32'd0;
        end else begin
            m_ovf = 1'b0;
            if (m_pend) begin
                if (string_ready) m_pend = 1'b0;
            end else if (s_axis_tvalid) begin
                msg.push_back(s_axis_tdata);
                if (s_axis_tlast) begin
                    if (msg.size() <= 55) begin
                        for (int i = 0; i < 56; i++) begin
                            if (i < msg.size())       m_words[i/4][8*(3-(i%4)) +: 8] = msg[i];
                            else if (i == msg.size()) m_words[i/4][8*(3-(i%4)) +: 8] = 8'h80;
                            else                      m_words[i/4][8*(3-(i%4)) +: 8] = 8'h00;
                        end
                        m_size = 8'(msg.size());
                        m_pend = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                    msg.delete();
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (chk_en) begin
            chk("dv", {31'd0, string_dv}, {31'd0, m_pend});
            chk("tready", {31'd0, s_axis_tready}, {31'd0, !m_pend});
            chk("overflow", {31'd0, overflow_err}, {31'd0, m_ovf});
            if (m_pend) begin
                for (int i = 0; i < 14; i++) chk($sformatf("word%0d", i), w[i], m_words[i]);
                chk("size", {24'd0, string_size}, {24'd0, m_size});
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit last);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                @(posedge aclk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_byte: byte %h not accepted within 200 cycles", d);
    endtask

    task automatic stop_valid();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        stop_valid();
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        string_ready  = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        chk_en  = 1'b1;
        chk("rst_dv", {31'd0, string_dv}, 32'd0);
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd1);
        chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
        chk("rst_size", {24'd0, string_size}, 32'd0);
        for (int i = 0; i < 14; i++) chk($sformatf("rst_w%0d", i), w[i], 32'd0);

        // "abc" with the core ready
        send_abc();
        stop_valid();
        chk("abc_dv", {31'd0, string_dv}, 32'd1);
        chk("abc_w0", w[0], 32'h61626380);
        chk("abc_w1", w[1], 32'd0);
        chk("abc_size", {24'd0, string_size}, 32'd3);
        chk("model_abc_w0", m_words[0], 32'h61626380);
        @(posedge aclk); #1;
        chk("abc_dv_drop", {31'd0, string_dv}, 32'd0);
        chk("abc_tready_back", {31'd0, s_axis_tready}, 32'd1);
        idle(3);

        // 55-byte maximum message
        for (int i = 0; i < 55; i++) send_byte(8'h41, i == 54);
        stop_valid();
        for (int i = 0; i < 13; i++) chk($sformatf("max_w%0d", i), w[i], 32'h41414141);
        chk("max_w13", w[13], 32'h41414180);
        chk("max_size", {24'd0, string_size}, 32'd55);
        chk("max_ovf", {31'd0, overflow_err}, 32'd0);
        chk("model_max_w13", m_words[13], 32'h41414180);
        idle(3);

        // 59-byte message is dropped with a single overflow pulse
        for (int i = 0; i < 59; i++) send_byte(8'(i + 1), i == 58);
        stop_valid();
        chk("ovf_pulse", {31'd0, overflow_err}, 32'd1);
        chk("ovf_no_dv", {31'd0, string_dv}, 32'd0);
        @(posedge aclk); #1;
        chk("ovf_one_cycle", {31'd0, overflow_err}, 32'd0);
        send_abc();
        stop_valid();
        chk("post_ovf_w0", w[0], 32'h61626380);
        chk("post_ovf_w13", w[13], 32'd0);
        idle(3);

        // Core stalls for 10 cycles
        string_ready = 1'b0;
        send_abc();
        stop_valid();
        repeat (9) @(posedge aclk);
        #1;
        chk("stall_dv_hold", {31'd0, string_dv}, 32'd1);
        chk("stall_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("stall_w0", w[0], 32'h61626380);
        string_ready = 1'b1;
        @(posedge aclk); #1;
        chk("stall_released_dv", {31'd0, string_dv}, 32'd0);
        chk("stall_released_tready", {31'd0, s_axis_tready}, 32'd1);
        idle(2);

        // Reset in the middle of a message
        for (int i = 0; i < 20; i++) send_byte(8'(8'h30 + i), 1'b0);
        stop_valid();
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        chk("mid_rst_w0", w[0], 32'd0);
        chk("mid_rst_tready", {31'd0, s_axis_tready}, 32'd1);
        send_byte(8'h61, 1'b1);
        stop_valid();
        chk("a_w0", w[0], 32'h61800000);
        chk("a_w1", w[1], 32'd0);
        chk("a_w4", w[4], 32'd0);
        chk("a_size", {24'd0, string_size}, 32'd1);
        idle(3);

        // Back-to-back "abc", "de" with tvalid held
        send_abc();
        send_byte(8'h64, 1'b0);
        send_byte(8'h65, 1'b1);
        stop_valid();
        chk("b2b_dv", {31'd0, string_dv}, 32'd1);
        chk("b2b_w0", w[0], 32'h64658000);
        chk("b2b_size", {24'd0, string_size}, 32'd2);
        chk("model_b2b_w0", m_words[0], 32'h64658000);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
